lsu_mem_ctrl: RTL and testbench

Load/store initiator for the single-cycle core's byte-addressed data memory.
- Accepts one RV32I load/store request at a time.
- Drives the memory's ce/we/addr/data_i port.
- Performs word-aligned accesses, with read-modify-write for SB/SH.
- Returns sign/zero-extended load data with a done pulse.
- Sits between the execute stage and the data memory.

---
 rtl/lsu_pkg.sv | 23 ++
 rtl/lsu_lane_unit.sv | 37 +++
 rtl/lsu_mem_ctrl.sv | 109 ++++++++++
 tb/tb_lsu_mem_ctrl.sv | 248 ++++++++++++++++++++++++
 4 files changed

// File: rtl/lsu_pkg.sv
// Shared definitions for the load/store unit: funct3 encodings, FSM states, legality check.
package lsu_pkg;

    localparam logic [2:0] F3_B  = 3'b000;
    localparam logic [2:0] F3_H  = 3'b001;
    localparam logic [2:0] F3_W  = 3'b010;
    localparam logic [2:0] F3_BU = 3'b100;
    localparam logic [2:0] F3_HU = 3'b101;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RD   = 2'd1,
        WR   = 2'd2,
        RESP = 2'd3
    } state_t;

    function automatic logic f3_legal(input logic store, input logic [2:0] f3);
        if (store)
            return (f3 == F3_B) || (f3 == F3_H) || (f3 == F3_W);
        return (f3 == F3_B) || (f3 == F3_H) || (f3 == F3_W) || (f3 == F3_BU) || (f3 == F3_HU);
    endfunction

endpackage

// File: rtl/lsu_lane_unit.sv
// Byte-lane steering: extracts/extends load data and merges SB/SH data into a word.
module lsu_lane_unit
    import lsu_pkg::*;
(
    input  logic [2:0]  funct3,
    input  logic [1:0]  lane,
    input  logic [31:0] old_word,
    input  logic [31:0] store_data,
    output logic [31:0] merged,
    output logic [31:0] load_val
);

    logic [7:0]  b;
    logic [15:0] h;

    always_comb begin
        b        = old_word[{lane, 3'b000} +: 8];
        h        = lane[1] ? old_word[31:16] : old_word[15:0];
        merged   = old_word;
        load_val = old_word;
        case (funct3)
            F3_B: begin
                load_val = {{24{b[7]}}, b};
                merged[{lane, 3'b000} +: 8] = store_data[7:0];
            end
            F3_BU: load_val = {24'h0, b};
            F3_H: begin
                load_val = {{16{h[15]}}, h};
                if (lane[1]) merged[31:16] = store_data[15:0];
                else         merged[15:0]  = store_data[15:0];
            end
            F3_HU: load_val = {16'h0, h};
            default: merged = store_data;
        endcase
    end

endmodule

// File: rtl/lsu_mem_ctrl.sv
// Single-outstanding load/store initiator for a word-wide, byte-addressed data memory.
module lsu_mem_ctrl
    import lsu_pkg::*;
#(
    parameter int MEM_BYTES = 1024,
    parameter int ADDR_W    = 32
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic              req_store,
    input  logic [2:0]        req_funct3,
    input  logic [ADDR_W-1:0] req_addr,
    input  logic [31:0]       req_wdata,
    output logic              rsp_done,
    output logic              rsp_err,
    output logic [31:0]       rsp_rdata,
    output logic              mem_ce,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [31:0]       mem_wdata,
    input  logic [31:0]       mem_rdata
);

    state_t            state;
    logic              st_store;
    logic [2:0]        st_f3;
    logic [ADDR_W-1:0] st_addr;
    logic [31:0]       st_wdata;
    logic [31:0]       wword;
    logic [31:0]       merged;
    logic [31:0]       load_val;
    logic              misalign;
    logic              out_of_range;
    logic              req_err;

    // funct3[1:0] encodes access size for every legal code; illegal codes are caught separately
    assign misalign     = ((req_funct3[1:0] == 2'b01) && req_addr[0]) ||
                          ((req_funct3[1:0] == 2'b10) && (req_addr[1:0] != 2'b00));
    assign out_of_range = {req_addr[ADDR_W-1:2], 2'b00} > ADDR_W'(MEM_BYTES - 4);
    assign req_err      = misalign || out_of_range || !f3_legal(req_store, req_funct3);

    lsu_lane_unit u_lane (
        .funct3     (st_f3),
        .lane       (st_addr[1:0]),
        .old_word   (mem_rdata),
        .store_data (st_wdata),
        .merged     (merged),
        .load_val   (load_val)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= IDLE;
            st_store  <= 1'b0;
            st_f3     <= 3'b000;
            st_addr   <= '0;
            st_wdata  <= '0;
            wword     <= '0;
            rsp_done  <= 1'b0;
            rsp_err   <= 1'b0;
            rsp_rdata <= '0;
        end else begin
            rsp_done  <= 1'b0;
            rsp_err   <= 1'b0;
            rsp_rdata <= '0;
            case (state)
                IDLE: if (req_valid) begin
                    st_store <= req_store;
                    st_f3    <= req_funct3;
                    st_addr  <= req_addr;
                    st_wdata <= req_wdata;
                    wword    <= req_wdata;
                    if (req_err) begin
                        state    <= RESP;
                        rsp_done <= 1'b1;
                        rsp_err  <= 1'b1;
                    end else if (req_store && (req_funct3 == F3_W)) begin
                        state <= WR;
                    end else begin
                        state <= RD;
                    end
                end
                RD: if (st_store) begin
                    wword <= merged;
                    state <= WR;
                end else begin
                    rsp_rdata <= load_val;
                    rsp_done  <= 1'b1;
                    state     <= RESP;
                end
                WR: begin
                    rsp_done <= 1'b1;
                    state    <= RESP;
                end
                RESP: state <= IDLE;
            endcase
        end
    end

    // Bus is decoded from state so an async reset drops ce/we immediately
    assign req_ready = (state == IDLE);
    assign mem_ce    = (state == RD) || (state == WR);
    assign mem_we    = (state == WR);
    assign mem_addr  = mem_ce ? {st_addr[ADDR_W-1:2], 2'b00} : '0;
    assign mem_wdata = mem_we ? wword : '0;

endmodule

// File: tb/tb_lsu_mem_ctrl.sv
// Directed + random bench for lsu_mem_ctrl against a byte-array reference memory.
module tb_lsu_mem_ctrl;

    localparam int MEM_BYTES = 1024;
    localparam int ADDR_W    = 32;

    logic              clk = 1'b0;
    logic              rst_n = 1'b0;
    logic              req_valid = 1'b0;
    logic              req_ready;
    logic              req_store = 1'b0;
    logic [2:0]        req_funct3 = 3'b000;
    logic [ADDR_W-1:0] req_addr = '0;
    logic [31:0]       req_wdata = '0;
    logic              rsp_done;
    logic              rsp_err;
    logic [31:0]       rsp_rdata;
    logic              mem_ce;
    logic              mem_we;
    logic [ADDR_W-1:0] mem_addr;
    logic [31:0]       mem_wdata;
    logic [31:0]       mem_rdata;

    logic [7:0] mem  [MEM_BYTES];
    logic [7:0] refm [MEM_BYTES];
    int errors = 0;
    int checks = 0;
    int wr_count = 0;

    always #5 clk = ~clk;

    lsu_mem_ctrl #(.MEM_BYTES(MEM_BYTES), .ADDR_W(ADDR_W)) dut (
        .clk(clk), .rst_n(rst_n),
        .req_valid(req_valid), .req_ready(req_ready), .req_store(req_store),
        .req_funct3(req_funct3), .req_addr(req_addr), .req_wdata(req_wdata),
        .rsp_done(rsp_done), .rsp_err(rsp_err), .rsp_rdata(rsp_rdata),
        .mem_ce(mem_ce), .mem_we(mem_we), .mem_addr(mem_addr),
        .mem_wdata(mem_wdata), .mem_rdata(mem_rdata)
    );

    assign mem_rdata = (mem_addr < 32'(MEM_BYTES)) ?
        {mem[mem_addr[9:0] + 10'd3], mem[mem_addr[9:0] + 10'd2],
         mem[mem_addr[9:0] + 10'd1], mem[mem_addr[9:0]]} : 32'h0;

    always @(posedge clk) begin
        if (mem_ce && mem_we) begin
            wr_count <= wr_count + 1;
            if (mem_addr < 32'(MEM_BYTES)) begin
                mem[mem_addr[9:0]]         <= mem_wdata[7:0];
                mem[mem_addr[9:0] + 10'd1] <= mem_wdata[15:8];
                mem[mem_addr[9:0] + 10'd2] <= mem_wdata[23:16];
                mem[mem_addr[9:0] + 10'd3] <= mem_wdata[31:24];
            end
        end
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %h, expected %h", tag, obs, exp);
        end
    endtask

    function automatic logic [31:0] ref_word(input int a);
        return {refm[a+3], refm[a+2], refm[a+1], refm[a]};
    endfunction

    function automatic logic [31:0] dut_word(input int a);
        return {mem[a+3], mem[a+2], mem[a+1], mem[a]};
    endfunction

    function automatic bit ref_err(input bit store, input logic [2:0] f3, input logic [31:0] addr);
        int size;
        if (store ? !(f3 inside {3'd0, 3'd1, 3'd2}) : !(f3 inside {3'd0, 3'd1, 3'd2, 3'd4, 3'd5}))
            return 1'b1;
        size = (f3[1:0] == 2'd0) ? 1 : (f3[1:0] == 2'd1) ? 2 : 4;
        if ((addr % size) != 0) return 1'b1;
        return (addr / 4) * 4 > MEM_BYTES - 4;
    endfunction

    function automatic logic [31:0] ref_load(input logic [2:0] f3, input int a);
        logic [7:0]  b;
        logic [15:0] h;
        b = refm[a];
        h = {refm[a+1], refm[a]};
        case (f3)
            3'd0:    return 32'($signed(b));
            3'd4:    return {24'h0, b};
            3'd1:    return 32'($signed(h));
            3'd5:    return {16'h0, h};
            default: return ref_word(a);
        endcase
    endfunction

    task automatic do_req(input bit store, input logic [2:0] f3, input logic [31:0] addr,
                          input logic [31:0] wdata, input string tag);
        bit          e;
        int          wa, lat, ce_n, we_n, exp_lat;
        logic [31:0] exp_rd, exp_wd, wd_obs;
        bit          addr_bad;
        e = ref_err(store, f3, addr);
        wa = int'(addr & ~32'h3);
        exp_rd = 32'h0;
        exp_wd = 32'h0;
        if (!e && !store) exp_rd = ref_load(f3, int'(addr));
        if (!e && store) begin
            refm[addr] = wdata[7:0];
            if (f3 != 3'd0) refm[addr+1] = wdata[15:8];
            if (f3 == 3'd2) begin
                refm[addr+2] = wdata[23:16];
                refm[addr+3] = wdata[31:24];
            end
            exp_wd = ref_word(wa);
        end
        exp_lat = e ? 1 : (store && f3 != 3'd2) ? 3 : 2;

        @(negedge clk);
        chk({tag, "_ready"}, 32'(req_ready), 32'd1);
        req_valid = 1'b1; req_store = store; req_funct3 = f3; req_addr = addr; req_wdata = wdata;
        @(posedge clk);
        #1;
        req_valid = 1'b0; req_store = 1'($urandom); req_funct3 = 3'($urandom);
        req_addr = $urandom; req_wdata = $urandom;

        lat = 0; ce_n = 0; we_n = 0; addr_bad = 1'b0; wd_obs = 32'h0;
        while (lat < 8) begin
            @(negedge clk);
            lat++;
            if (mem_ce) begin
                ce_n++;
                if (mem_addr !== 32'(wa)) addr_bad = 1'b1;
            end
            if (mem_we) begin
                we_n++;
                wd_obs = mem_wdata;
            end
            if (rsp_done === 1'b1) break;
        end
        chk({tag, "_latency"}, 32'(lat), 32'(exp_lat));
        chk({tag, "_err"}, 32'(rsp_err), 32'(e));
        chk({tag, "_rdata"}, rsp_rdata, exp_rd);
        chk({tag, "_ce_cycles"}, 32'(ce_n), e ? 32'd0 : 32'(exp_lat - 1));
        chk({tag, "_we_cycles"}, 32'(we_n), (store && !e) ? 32'd1 : 32'd0);
        chk({tag, "_mem_addr"}, 32'(addr_bad), 32'd0);
        if (store && !e) chk({tag, "_mem_wdata"}, wd_obs, exp_wd);
        @(negedge clk);
        chk({tag, "_done_pulse"}, 32'(rsp_done), 32'd0);
        chk({tag, "_ready_after"}, 32'(req_ready), 32'd1);
        if (wa <= MEM_BYTES - 4) chk({tag, "_memword"}, dut_word(wa), ref_word(wa));
    endtask

    initial begin
        int          wc0;
        logic [31:0] w0, exp0, exp4;
        for (int i = 0; i < MEM_BYTES; i++) begin
            mem[i]  = 8'($urandom);
            refm[i] = mem[i];
        end
        {mem[15], mem[14], mem[13], mem[12]} = 32'h8877_6655;
        {refm[15], refm[14], refm[13], refm[12]} = 32'h8877_6655;

        #12;
        chk("rst_ready", 32'(req_ready), 32'd1);
        chk("rst_ce", 32'(mem_ce), 32'd0);
        chk("rst_we", 32'(mem_we), 32'd0);
        chk("rst_addr", mem_addr, 32'd0);
        chk("rst_wdata", mem_wdata, 32'd0);
        chk("rst_done", 32'(rsp_done), 32'd0);
        chk("rst_err", 32'(rsp_err), 32'd0);
        chk("rst_rdata", rsp_rdata, 32'd0);
        @(negedge clk);
        rst_n = 1'b1;

        do_req(1'b0, 3'd0, 32'h0F, 32'h0, "lb_0f");
        do_req(1'b0, 3'd4, 32'h0F, 32'h0, "lbu_0f");
        do_req(1'b1, 3'd2, 32'h10, 32'hDEAD_BEEF, "sw_10");
        do_req(1'b0, 3'd2, 32'h10, 32'h0, "lw_10");
        do_req(1'b1, 3'd0, 32'h11, 32'h0000_00A5, "sb_11");
        do_req(1'b1, 3'd1, 32'h12, 32'h0000_1234, "sh_12");
        do_req(1'b0, 3'd2, 32'h10, 32'h0, "lw_10b");
        do_req(1'b0, 3'd1, 32'h13, 32'h0, "lh_mis");
        do_req(1'b1, 3'd2, 32'h0E, 32'h1111_2222, "sw_mis");
        do_req(1'b0, 3'd2, 32'h400, 32'h0, "lw_range");
        do_req(1'b0, 3'd3, 32'h08, 32'h0, "ld_f3_011");
        do_req(1'b1, 3'd4, 32'h08, 32'h5555_5555, "st_f3_100");
        do_req(1'b0, 3'd2, 32'h3FC, 32'h0, "lw_top");

        // reset during the read half of an SB
        wc0 = wr_count;
        w0 = ref_word(32'h20);
        @(negedge clk);
        req_valid = 1'b1; req_store = 1'b1; req_funct3 = 3'd0; req_addr = 32'h20; req_wdata = $urandom;
        @(posedge clk);
        #1 req_valid = 1'b0;
        @(negedge clk);
        chk("rst_mid_ce_before", 32'(mem_ce), 32'd1);
        #1 rst_n = 1'b0;
        #1;
        chk("rst_mid_ce", 32'(mem_ce), 32'd0);
        chk("rst_mid_we", 32'(mem_we), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            chk("rst_mid_no_done", 32'(rsp_done), 32'd0);
        end
        chk("rst_mid_ready", 32'(req_ready), 32'd1);
        chk("rst_mid_writes", 32'(wr_count), 32'(wc0));
        chk("rst_mid_word", dut_word(32'h20), w0);

        // req_valid held across two back-to-back loads
        exp0 = ref_word(0);
        exp4 = ref_word(4);
        @(negedge clk);
        req_valid = 1'b1; req_store = 1'b0; req_funct3 = 3'd2; req_addr = 32'h00;
        @(posedge clk);
        #1 req_addr = 32'h04;
        @(negedge clk);
        chk("b2b_busy_ready", 32'(req_ready), 32'd0);
        @(negedge clk);
        chk("b2b_done0", 32'(rsp_done), 32'd1);
        chk("b2b_rdata0", rsp_rdata, exp0);
        chk("b2b_ready_in_resp", 32'(req_ready), 32'd0);
        @(negedge clk);
        chk("b2b_ready_idle", 32'(req_ready), 32'd1);
        chk("b2b_no_ce_idle", 32'(mem_ce), 32'd0);
        @(posedge clk);
        #1 req_valid = 1'b0;
        @(negedge clk);
        chk("b2b_ce1", 32'(mem_ce), 32'd1);
        chk("b2b_addr1", mem_addr, 32'h04);
        @(negedge clk);
        chk("b2b_done1", 32'(rsp_done), 32'd1);
        chk("b2b_rdata1", rsp_rdata, exp4);

        for (int n = 0; n < 60; n++) begin
            logic [31:0] a;
            a = 32'($urandom_range(0, MEM_BYTES + 8));
            if ($urandom_range(0, 1) == 1) a = a & ~32'h3;
            do_req(1'($urandom), 3'($urandom), a, $urandom, "rand");
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
